// File: rtl/sram_rr_arbiter.sv
// Two-master round-robin arbiter and sequencer in front of a single-port SRAM.
// Each granted access runs IDLE -> ISSUE (-> RESP for reads) -> IDLE, so only
// one access is ever in flight. All outputs come straight from flops.
// Read data is returned one cycle after the SRAM registers it.
// Addresses at or beyond DEPTH are granted but never reach the SRAM port.
module sram_rr_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state_q,      state_d;
    logic              last_grant_q, last_grant_d;  // 0 = m0, 1 = m1
    logic              owner_q,      owner_d;
    logic              we_q,         we_d;
    logic              oor_q,        oor_d;         // latched address out of range
    logic              m0_gnt_q,     m0_gnt_d;
    logic              m1_gnt_q,     m1_gnt_d;
    logic              m0_rvalid_q,  m0_rvalid_d;
    logic              m1_rvalid_q,  m1_rvalid_d;
    logic [DATA_W-1:0] m0_rdata_q,   m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q,   m1_rdata_d;
    logic              sram_cs_q,    sram_cs_d;
    logic              sram_we_q,    sram_we_d;
    logic [ADDR_W-1:0] sram_addr_q,  sram_addr_d;
    logic [DATA_W-1:0] sram_din_q,   sram_din_d;

    logic              pick_m1;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_in_range;
    logic [DATA_W-1:0] resp_data;

    // Winner selection: a lone requester always wins, on contention the master
    // that was not granted last time wins.
    always_comb begin
        pick_m1      = m1_req && (!m0_req || !last_grant_q);
        win_we       = pick_m1 ? m1_we    : m0_we;
        win_addr     = pick_m1 ? m1_addr  : m0_addr;
        win_wdata    = pick_m1 ? m1_wdata : m0_wdata;
        win_in_range = ({1'b0, win_addr} < DEPTH_EXT);
        resp_data    = oor_q ? '0 : sram_dout;
    end

    // Sequencer next-state: the SRAM strobe is launched together with the
    // grant so that it is visible during ISSUE.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        oor_d        = oor_q;
        m0_gnt_d     = 1'b0;
        m1_gnt_d     = 1'b0;
        m0_rvalid_d  = 1'b0;
        m1_rvalid_d  = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        sram_cs_d    = 1'b0;
        sram_we_d    = 1'b0;
        sram_addr_d  = sram_addr_q;
        sram_din_d   = sram_din_q;

        case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d      = ST_ISSUE;
                    owner_d      = pick_m1;
                    last_grant_d = pick_m1;
                    we_d         = win_we;
                    oor_d        = !win_in_range;
                    m0_gnt_d     = !pick_m1;
                    m1_gnt_d     = pick_m1;
                    // Out-of-range accesses leave the SRAM port untouched.
                    if (win_in_range) begin
                        sram_cs_d   = 1'b1;
                        sram_we_d   = win_we;
                        sram_addr_d = win_addr;
                        sram_din_d  = win_wdata;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = we_q ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                // sram_dout now holds the word registered at the end of ISSUE.
                state_d = ST_IDLE;
                if (owner_q) begin
                    m1_rdata_d  = resp_data;
                    m1_rvalid_d = 1'b1;
                end else begin
                    m0_rdata_d  = resp_data;
                    m0_rvalid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight access at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            oor_q        <= 1'b0;
            m0_gnt_q     <= 1'b0;
            m1_gnt_q     <= 1'b0;
            m0_rvalid_q  <= 1'b0;
            m1_rvalid_q  <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            sram_cs_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_din_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            oor_q        <= oor_d;
            m0_gnt_q     <= m0_gnt_d;
            m1_gnt_q     <= m1_gnt_d;
            m0_rvalid_q  <= m0_rvalid_d;
            m1_rvalid_q  <= m1_rvalid_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            sram_cs_q    <= sram_cs_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_din_q   <= sram_din_d;
        end
    end

    assign m0_gnt    = m0_gnt_q;
    assign m1_gnt    = m1_gnt_q;
    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign sram_cs   = sram_cs_q;
    assign sram_we   = sram_we_q;
    assign sram_addr = sram_addr_q;
    assign sram_din  = sram_din_q;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: directed master transactions, a behavioural
// single-port SRAM with registered read, and a negedge monitor that checks
// grants, SRAM strobes and read responses against hand-computed queues.
module tb_sram_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        preload;
    logic        req_v  [2];
    logic        we_v   [2];
    logic [7:0]  addr_v [2];
    logic [31:0] wd_v   [2];

    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        sram_cs, sram_we;
    logic [7:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] din;
    } acc_t;

    int          gnt_exp [$];
    acc_t        acc_exp [$];
    logic [31:0] rd0_exp [$];
    logic [31:0] rd1_exp [$];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int gnt_cyc [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_rr_arbiter #(.ADDR_W(8), .DATA_W(32), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (req_v[0]),
        .m0_we     (we_v[0]),
        .m0_addr   (addr_v[0]),
        .m0_wdata  (wd_v[0]),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (req_v[1]),
        .m1_we     (we_v[1]),
        .m1_addr   (addr_v[1]),
        .m1_wdata  (wd_v[1]),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .sram_cs   (sram_cs),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    // Behavioural SRAM: write on cs&we, registered read on cs&!we.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[0] <= 32'hA0A0A0A0;
            mem[1] <= 32'h00000011;
            mem[2] <= 32'h00000022;
            mem[5] <= 32'h55555555;
        end else if (sram_cs && sram_we) begin
            mem[sram_addr] <= sram_din;
        end
    end
    always @(posedge clk or posedge rst) begin
        if (rst) sram_dout <= 32'h0;
        else if (sram_cs && !sram_we) sram_dout <= mem[sram_addr];
    end

    function automatic logic gnt_of(input int m);
        return (m == 0) ? m0_gnt : m1_gnt;
    endfunction
    function automatic logic rvalid_of(input int m);
        return (m == 0) ? m0_rvalid : m1_rvalid;
    endfunction
    function automatic logic [31:0] rdata_of(input int m);
        return (m == 0) ? m0_rdata : m1_rdata;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        fails++;
        $display("FAIL %s: got %h, expected no event (cycle %0d)", name, act, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk) begin
        if (!rst) begin
            if (m0_gnt || m1_gnt) chk("dual_gnt", 32'(m0_gnt & m1_gnt), 32'd0);
            for (int m = 0; m < 2; m++) begin
                if (gnt_of(m)) begin
                    gnt_cyc[m] = cyc;
                    $display("txn: m%0d granted at cycle %0d", m, cyc);
                    if (gnt_exp.size() == 0) unexpected("gnt", 32'(m));
                    else chk("gnt_order", 32'(m), 32'(gnt_exp.pop_front()));
                end
                if (rvalid_of(m)) begin
                    $display("txn: m%0d read data %h at cycle %0d", m, rdata_of(m), cyc);
                    chk("rvalid_latency", 32'(cyc - gnt_cyc[m]), 32'd2);
                    if (m == 0) begin
                        if (rd0_exp.size() == 0) unexpected("m0_rvalid", rdata_of(m));
                        else chk("m0_rdata", rdata_of(m), rd0_exp.pop_front());
                    end else begin
                        if (rd1_exp.size() == 0) unexpected("m1_rvalid", rdata_of(m));
                        else chk("m1_rdata", rdata_of(m), rd1_exp.pop_front());
                    end
                end
            end
            if (sram_cs) begin
                chk("cs_with_gnt", 32'(m0_gnt | m1_gnt), 32'd1);
                if (acc_exp.size() == 0) begin
                    unexpected("sram_cs", 32'(sram_addr));
                end else begin
                    acc_t e;
                    e = acc_exp.pop_front();
                    chk("sram_we", 32'(sram_we), 32'(e.we));
                    chk("sram_addr", 32'(sram_addr), 32'(e.addr));
                    if (e.we) chk("sram_din", sram_din, e.din);
                end
            end
        end
    end

    task automatic push_acc(input logic w, input logic [7:0] a, input logic [31:0] d);
        acc_t e;
        e.we = w; e.addr = a; e.din = d;
        acc_exp.push_back(e);
    endtask

    // Present one request and hold it until the grant is seen.
    task automatic access(input int m, input logic w, input logic [7:0] a, input logic [31:0] d);
        int n;
        n = 0;
        req_v[m] = 1'b1; we_v[m] = w; addr_v[m] = a; wd_v[m] = d;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!gnt_of(m) && n < 100);
        if (!gnt_of(m)) unexpected("gnt_timeout", 32'(m));
        req_v[m] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((gnt_exp.size() + acc_exp.size() + rd0_exp.size() + rd1_exp.size()) != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("queues_drained", 32'(gnt_exp.size() + acc_exp.size() + rd0_exp.size() + rd1_exp.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; preload = 1'b1;
        for (int m = 0; m < 2; m++) begin
            req_v[m] = 1'b0; we_v[m] = 1'b0; addr_v[m] = 8'h0; wd_v[m] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; preload = 1'b0;
        #1;
        chk("rst_m0_gnt",    32'(m0_gnt),    32'd0);
        chk("rst_m1_gnt",    32'(m1_gnt),    32'd0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("rst_sram_cs",   32'(sram_cs),   32'd0);
        chk("rst_sram_we",   32'(sram_we),   32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_sram_din",  sram_din,       32'd0);
        chk("rst_m0_rdata",  m0_rdata,       32'd0);
        chk("rst_m1_rdata",  m1_rdata,       32'd0);

        // Contention right after reset: m0 first, then m1.
        gnt_exp.push_back(0); gnt_exp.push_back(1);
        push_acc(1'b0, 8'd1, 32'h0); push_acc(1'b0, 8'd2, 32'h0);
        rd0_exp.push_back(32'h11); rd1_exp.push_back(32'h22);
        fork
            access(0, 1'b0, 8'd1, 32'h0);
            access(1, 1'b0, 8'd2, 32'h0);
        join
        drain();

        // Both held high for six transactions: strict alternation from m0.
        for (int i = 0; i < 3; i++) begin
            gnt_exp.push_back(0); gnt_exp.push_back(1);
        end
        push_acc(1'b1, 8'd4, 32'h40); push_acc(1'b0, 8'd2, 32'h0);
        push_acc(1'b0, 8'd4, 32'h0);  push_acc(1'b1, 8'd6, 32'h66);
        push_acc(1'b1, 8'd4, 32'h44); push_acc(1'b0, 8'd6, 32'h0);
        rd0_exp.push_back(32'h40);
        rd1_exp.push_back(32'h22); rd1_exp.push_back(32'h66);
        fork
            begin
                access(0, 1'b1, 8'd4, 32'h40);
                access(0, 1'b0, 8'd4, 32'h0);
                access(0, 1'b1, 8'd4, 32'h44);
            end
            begin
                access(1, 1'b0, 8'd2, 32'h0);
                access(1, 1'b1, 8'd6, 32'h66);
                access(1, 1'b0, 8'd6, 32'h0);
            end
        join
        drain();

        // m0 write then read of addr 3; m1 untouched.
        gnt_exp.push_back(0); gnt_exp.push_back(0);
        push_acc(1'b1, 8'd3, 32'hDEADBEEF); push_acc(1'b0, 8'd3, 32'h0);
        rd0_exp.push_back(32'hDEADBEEF);
        access(0, 1'b1, 8'd3, 32'hDEADBEEF);
        access(0, 1'b0, 8'd3, 32'h0);
        drain();
        chk("m1_rdata_held", m1_rdata, 32'h66);

        // m1 alone, three back-to-back grants despite having lost last time.
        gnt_exp.push_back(1); gnt_exp.push_back(1); gnt_exp.push_back(1);
        push_acc(1'b1, 8'd7, 32'h77); push_acc(1'b1, 8'd7, 32'h78); push_acc(1'b0, 8'd7, 32'h0);
        rd1_exp.push_back(32'h78);
        access(1, 1'b1, 8'd7, 32'h77);
        access(1, 1'b1, 8'd7, 32'h78);
        access(1, 1'b0, 8'd7, 32'h0);
        drain();

        // Out-of-range write and read at DEPTH, then addr 0 is intact.
        gnt_exp.push_back(1); gnt_exp.push_back(1); gnt_exp.push_back(1);
        push_acc(1'b0, 8'd0, 32'h0);
        rd1_exp.push_back(32'h0); rd1_exp.push_back(32'hA0A0A0A0);
        access(1, 1'b1, 8'd8, 32'hFFFFFFFF);
        access(1, 1'b0, 8'd8, 32'h0);
        access(1, 1'b0, 8'd0, 32'h0);
        drain();
        chk("m0_rdata_held", m0_rdata, 32'hDEADBEEF);

        // m0 read of addr 5 races an m1 write to it; the read sees the old word.
        gnt_exp.push_back(0); gnt_exp.push_back(1); gnt_exp.push_back(0);
        push_acc(1'b0, 8'd5, 32'h0); push_acc(1'b1, 8'd5, 32'h5A5A5A5A); push_acc(1'b0, 8'd5, 32'h0);
        rd0_exp.push_back(32'h55555555); rd0_exp.push_back(32'h5A5A5A5A);
        fork
            access(0, 1'b0, 8'd5, 32'h0);
            access(1, 1'b1, 8'd5, 32'h5A5A5A5A);
        join
        access(0, 1'b0, 8'd5, 32'h0);
        drain();
        chk("m1_rdata_unchanged", m1_rdata, 32'hA0A0A0A0);

        // Reset during ISSUE of an m0 read: everything drops at once.
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 8'd1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!m0_gnt && n < 100);
        chk("abort_gnt_seen", 32'(m0_gnt), 32'd1);
        rst = 1'b1;
        req_v[0] = 1'b0;
        #1;
        chk("abort_sram_cs",   32'(sram_cs),   32'd0);
        chk("abort_m0_gnt",    32'(m0_gnt),    32'd0);
        chk("abort_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("abort_m0_rdata",  m0_rdata,       32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_rvalid", 32'(m0_rvalid), 32'd0);

        // Contention after reset is won by m0 again.
        gnt_exp.push_back(0); gnt_exp.push_back(1);
        push_acc(1'b0, 8'd1, 32'h0); push_acc(1'b0, 8'd2, 32'h0);
        rd0_exp.push_back(32'h11); rd1_exp.push_back(32'h22);
        fork
            access(0, 1'b0, 8'd1, 32'h0);
            access(1, 1'b0, 8'd2, 32'h0);
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port SRAM (`sram` module) in the AXI-SRAM subsystem.
- Serialises masters m0 and m1 onto one cs/we/addr/din port.
- Accounts for the SRAM's registered one-cycle read latency and returns read data to the owning master.
- Rejects out-of-range addresses without touching the SRAM.

Parameters:
- ADDR_W, 8, address width of requester and SRAM address ports.
- DATA_W, 32, data word width.
- DEPTH, 8, number of implemented SRAM words; valid addresses are 0..DEPTH-1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high; the top level drives the SRAM's active-low reset with ~rst.
- m0_req  input  1  m0 access request; held with m0_we/m0_addr/m0_wdata stable until m0_gnt.
- m0_we  input  1  1=write, 0=read.
- m0_addr  input  ADDR_W  word address.
- m0_wdata  input  DATA_W  write data.
- m0_gnt  output  1  one-cycle pulse: m0 request issued.
- m0_rvalid  output  1  one-cycle pulse: m0_rdata valid.
- m0_rdata  output  DATA_W  read data; holds its value until the next m0 read response.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: identical to m0.
- sram_cs  output  1  SRAM chip select.
- sram_we  output  1  SRAM write enable.
- sram_addr  output  ADDR_W  SRAM address.
- sram_din  output  DATA_W  SRAM write data.
- sram_dout  input  DATA_W  SRAM registered read data.

Behaviour:
- All outputs are registered. Reset values:
  - all gnt, rvalid, sram_cs, sram_we = 0
  - sram_addr, sram_din, m0_rdata, m1_rdata = 0
  - state = IDLE
  - last_grant = 1, so m0 wins the first contention.
- Reset mid-operation: every output drops to reset value immediately (async). In-flight access is aborted; no gnt or rvalid is produced for it.
- FSM states: IDLE, ISSUE, RESP.
- IDLE, cycle T, no request: remain in IDLE, sram_cs = 0.
- IDLE, cycle T, any req=1, winner selection:
  - Only one master requesting: that master wins.
  - Both requesting: the master != last_grant wins.
- IDLE, cycle T, on the clock edge after selection:
  - Latch the winner's we/addr/wdata.
  - Set owner = winner and last_grant = winner.
  - Pulse owner's gnt in T+1.
  - Go to ISSUE.
- ISSUE, cycle T+1:
  - If addr < DEPTH: sram_cs = 1, sram_we/addr/din = latched values.
  - Else: sram_cs = 0 (access suppressed).
  - Next state: write → IDLE; read → RESP.
- RESP, cycle T+2:
  - On exit: owner's rdata <= sram_dout, or 0 if addr was out of range; owner's rvalid pulses in T+3.
  - Next state: IDLE.
- Occupancy and latency:
  - Write occupies 2 cycles. Read occupies 3 cycles, with rvalid 3 cycles after the request is first sampled.
  - A new request may be sampled in IDLE in the same cycle an rvalid is visible.
- Requests are not sampled in ISSUE or RESP. Masters keep req high, with stable payload, until they see gnt.
  - A master sampling gnt may deassert req or present a new request in the following cycle.
  - A req still high with the same payload after gnt is treated as a new request.
- Both masters requesting continuously: grants alternate m0, m1, m0, ...
  - A lone requester is granted back-to-back regardless of last_grant.
- Out-of-range address (addr >= DEPTH):
  - Write: gnt given, SRAM untouched.
  - Read: gnt given, rvalid with rdata = 0.
- The non-owning master's rvalid stays 0 and its rdata is unchanged.
- sram_addr/sram_din hold their last values when sram_cs = 0. Only sram_cs qualifies them.

Test Plan:
- Reset, then m0 writes addr 3 = 0xDEADBEEF, then m0 reads addr 3 → m0_gnt pulses 1 cycle after each request sample. sram_cs high for exactly 1 cycle per access with sram_we = 1 then 0. m0_rvalid 3 cycles after the read request with m0_rdata = 0xDEADBEEF. m1 outputs stay 0.
- Both masters request reads simultaneously right after reset (m0 addr 1, m1 addr 2, preloaded 0x11/0x22) → m0 granted first, m1 granted next. Responses 0x11 on m0, then 0x22 on m1. No overlapping sram_cs.
- Both req held high for 6 transactions → grant order m0, m1, m0, m1, m0, m1. m1 alone for 3 transactions → three consecutive m1 grants.
- m1 writes addr 8 (DEPTH = 8) with 0xFFFFFFFF, then reads addr 8 → m1_gnt twice, sram_cs never asserted, m1_rvalid with m1_rdata = 0. A following read of addr 0 returns its previous contents.
- rst asserted during ISSUE of an m0 read → sram_cs, m0_gnt and m0_rvalid drop to 0 immediately. No m0_rvalid after rst deasserts. The next contention is won by m0.
- m0 read of addr 5 followed immediately by m1 write to addr 5 of 0x5A5A5A5A → m0_rdata equals the pre-write value. A subsequent m0 read returns 0x5A5A5A5A.
